// File: rtl/dht_disp_pkg.sv
// Shared types and constants for the sensor-to-BCD display formatter.
// DHT_BCD_SATURATE_EN (see dht_bcd_formatter.sv) selects clamping of values >= 100 to 99.
package dht_disp_pkg;
  localparam int BCD_W          = 4;
  localparam int DABBLE_STEPS   = 8;
  localparam int ALT_PERIOD_DEF = 25_000_000;
  localparam int ALT_CNT_W      = 26;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CONV = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  typedef struct packed {
    state_e            state;
    logic              pending;
    logic [BCD_W-1:0]  hundreds;
  } dbg_t;

  // Double-dabble correction: a digit of 5 or more would overflow past 9 after the shift.
  function automatic logic [BCD_W-1:0] add3(input logic [BCD_W-1:0] d);
    return (d >= BCD_W'(5)) ? d + BCD_W'(3) : d;
  endfunction
endpackage

// File: rtl/dht_bcd_formatter_if.sv
// Sensor-reading input and BCD digit output bundle of dht_bcd_formatter.
// data_valid is a one-cycle strobe with no ready: the formatter always accepts it.
interface dht_bcd_formatter_if;
  import dht_disp_pkg::*;

  logic             data_valid;
  logic [7:0]       humidity;
  logic [7:0]       temperature;
  logic [BCD_W-1:0] tens;
  logic [BCD_W-1:0] ones;
  logic             src;
  logic             busy;
  logic             done;
  dbg_t             dbg;

  modport master (
    output data_valid, humidity, temperature,
    input  tens, ones, src, busy, done, dbg
  );

  modport slave (
    input  data_valid, humidity, temperature,
    output tens, ones, src, busy, done, dbg
  );
endinterface

// File: rtl/bcd_dabble_core.sv
// Sequential 8-bit binary to 12-bit BCD converter: load, then one shift-and-add-3 per step.
module bcd_dabble_core
  import dht_disp_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               load,
  input  logic               step,
  input  logic [7:0]         din,
  output logic [3*BCD_W-1:0] bcd
);
  logic [7:0]         sr_q, sr_d;
  logic [3*BCD_W-1:0] bcd_q, bcd_d;
  logic [3*BCD_W-1:0] adj;
  logic [3*BCD_W+7:0] shifted;

  always_comb begin
    adj     = {add3(bcd_q[11:8]), add3(bcd_q[7:4]), add3(bcd_q[3:0])};
    shifted = {adj, sr_q} << 1;
    sr_d    = sr_q;
    bcd_d   = bcd_q;
    if (load) begin
      sr_d  = din;
      bcd_d = '0;
    end else if (step) begin
      bcd_d = shifted[3*BCD_W+7:8];
      sr_d  = shifted[7:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sr_q  <= '0;
      bcd_q <= '0;
    end else begin
      sr_q  <= sr_d;
      bcd_q <= bcd_d;
    end
  end

  assign bcd = bcd_q;
endmodule

// File: rtl/dht_bcd_formatter.sv
// Alternates humidity/temperature readings into two registered BCD digits for a display.
// Define DHT_BCD_SATURATE_EN to show 9,9 for values >= 100 instead of the low two digits.
module dht_bcd_formatter
  import dht_disp_pkg::*;
#(
  parameter int ALT_PERIOD = ALT_PERIOD_DEF
) (
  input logic                 clk,
  input logic                 rst_n,
  dht_bcd_formatter_if.slave  bus
);
  localparam logic [ALT_CNT_W-1:0] ALT_LAST  = ALT_CNT_W'(ALT_PERIOD - 1);
  localparam logic [2:0]           STEP_LAST = 3'(DABBLE_STEPS - 1);

  state_e               state_q, state_d;
  logic [2:0]           step_cnt_q, step_cnt_d;
  logic [ALT_CNT_W-1:0] alt_cnt_q, alt_cnt_d;
  logic                 alt_src_q, alt_src_d;
  logic                 pending_q, pending_d;
  logic                 conv_src_q, conv_src_d;
  logic [7:0]           hold_h_q, hold_h_d;
  logic [7:0]           hold_t_q, hold_t_d;
  logic [BCD_W-1:0]     tens_q, tens_d;
  logic [BCD_W-1:0]     ones_q, ones_d;
  logic                 src_q, src_d;
  logic                 done_q, done_d;

  logic                 wrap, req, load, step;
  logic [7:0]           sel_h, sel_t, din;
  logic [3*BCD_W-1:0]   bcd;

  bcd_dabble_core u_core (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (load),
    .step  (step),
    .din   (din),
    .bcd   (bcd)
  );

  always_comb begin
    wrap      = (alt_cnt_q == ALT_LAST);
    alt_cnt_d = wrap ? '0 : alt_cnt_q + 1'b1;
    alt_src_d = alt_src_q ^ wrap;
    req       = bus.data_valid | wrap;
    // A reading arriving with the request is converted directly, not the stale hold value.
    sel_h     = bus.data_valid ? bus.humidity    : hold_h_q;
    sel_t     = bus.data_valid ? bus.temperature : hold_t_q;
    din       = alt_src_d ? sel_t : sel_h;
    hold_h_d  = sel_h;
    hold_t_d  = sel_t;

    state_d    = state_q;
    step_cnt_d = step_cnt_q;
    pending_d  = pending_q;
    conv_src_d = conv_src_q;
    tens_d     = tens_q;
    ones_d     = ones_q;
    src_d      = src_q;
    done_d     = 1'b0;
    load       = 1'b0;
    step       = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (req || pending_q) begin
          state_d    = ST_CONV;
          load       = 1'b1;
          step_cnt_d = '0;
          conv_src_d = alt_src_d;
          pending_d  = 1'b0;
        end
      end
      ST_CONV: begin
        step       = 1'b1;
        step_cnt_d = step_cnt_q + 1'b1;
        if (req) pending_d = 1'b1;
        if (step_cnt_q == STEP_LAST) state_d = ST_DONE;
      end
      ST_DONE: begin
        if (req) pending_d = 1'b1;
        state_d = ST_IDLE;
        src_d   = conv_src_q;
        done_d  = 1'b1;
`ifdef DHT_BCD_SATURATE_EN
        if (bcd[11:8] != '0) begin
          tens_d = BCD_W'(9);
          ones_d = BCD_W'(9);
        end else begin
          tens_d = bcd[7:4];
          ones_d = bcd[3:0];
        end
`else
        tens_d = bcd[7:4];
        ones_d = bcd[3:0];
`endif
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      step_cnt_q <= '0;
      alt_cnt_q  <= '0;
      alt_src_q  <= 1'b0;
      pending_q  <= 1'b0;
      conv_src_q <= 1'b0;
      hold_h_q   <= '0;
      hold_t_q   <= '0;
      tens_q     <= '0;
      ones_q     <= '0;
      src_q      <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      step_cnt_q <= step_cnt_d;
      alt_cnt_q  <= alt_cnt_d;
      alt_src_q  <= alt_src_d;
      pending_q  <= pending_d;
      conv_src_q <= conv_src_d;
      hold_h_q   <= hold_h_d;
      hold_t_q   <= hold_t_d;
      tens_q     <= tens_d;
      ones_q     <= ones_d;
      src_q      <= src_d;
      done_q     <= done_d;
    end
  end

  assign bus.tens = tens_q;
  assign bus.ones = ones_q;
  assign bus.src  = src_q;
  assign bus.done = done_q;
  assign bus.busy = (state_q != ST_IDLE);
  assign bus.dbg  = '{state: state_q, pending: pending_q, hundreds: bcd[11:8]};
endmodule

// File: doc/dht_bcd_formatter.md
DHT_BCD_FORMATTER -- requirements
Module: dht_bcd_formatter

Interface
REQ-001 SHALL have parameter ALT_PERIOD, default 25_000_000, cycles between humidity/temperature source toggles (1 s at 25 MHz); legal range 16..2^26-1.
REQ-002 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-003 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port data_valid  input  1  one-cycle pulse, new sensor reading present.
REQ-005 SHALL have port humidity  input  8  unsigned integer %RH, sampled when data_valid=1.
REQ-006 SHALL have port temperature  input  8  unsigned integer degC, sampled when data_valid=1.
REQ-007 SHALL have port tens  output  4  registered BCD tens digit for the display stage.
REQ-008 SHALL have port ones  output  4  registered BCD ones digit for the display stage.
REQ-009 SHALL have port src  output  1  source of current digits: 0 humidity, 1 temperature.
REQ-010 SHALL have port busy  output  1  high while a conversion is in progress.
REQ-011 SHALL have port done  output  1  one-cycle pulse when tens/ones/src update.

Function
REQ-012 SHALL latch humidity and temperature into hold registers on every cycle with data_valid=1, regardless of state.
REQ-013 SHALL implement FSM IDLE -> CONV -> DONE -> IDLE.
REQ-014 IDLE -> CONV SHALL occur on the edge following a conversion request (data_valid, alternation tick, or a pending request).
REQ-015 CONV SHALL run exactly 8 cycles of shift-and-add-3 (double dabble) on the selected hold byte; 12-bit BCD result (hundreds, tens, ones).
REQ-016 DONE SHALL last 1 cycle: tens, ones, src registered, done=1; total latency from request edge to done edge 10 cycles.
REQ-017 busy SHALL be 1 in CONV and DONE, 0 in IDLE.
REQ-018 The selected byte SHALL be humidity when the next src is 0, temperature when 1; next src is computed at request time.
REQ-019 An alternation counter SHALL count 0..ALT_PERIOD-1 and wrap; at wrap it SHALL toggle the next src and raise a request.
REQ-020 A request arriving while busy SHALL set a single pending flag (not queued further); it SHALL be serviced in the cycle after DONE, using the hold registers current at that time.
REQ-021 Simultaneous data_valid and alternation wrap SHALL produce one conversion of the toggled source with the new data.
REQ-022 tens/ones SHALL hold their value between done pulses; no intermediate dabble value SHALL appear on outputs.

Reset
REQ-023 rst_n=0 SHALL immediately force: tens=0, ones=0, src=0, busy=0, done=0, hold registers=0, pending=0, alternation counter=0, FSM=IDLE.
REQ-024 Reset asserted mid-conversion SHALL abandon the conversion; no done pulse SHALL follow deassertion without a new request.
REQ-025 The first alternation wrap after reset deassertion SHALL occur ALT_PERIOD cycles later.

Configuration
REQ-026 Macro DHT_BCD_SATURATE_EN defined: result with hundreds digit nonzero (value >= 100) SHALL output tens=9, ones=9.
REQ-027 Macro DHT_BCD_SATURATE_EN undefined: value >= 100 SHALL output the low two BCD digits (e.g. 123 -> 2,3); hundreds discarded.

Structure
REQ-028 Shared package dht_disp_pkg SHALL hold the FSM state enum, BCD_W=4, DABBLE_STEPS=8, and the ALT_PERIOD default constant.
REQ-029 The double-dabble datapath SHALL be a sub-module bcd_dabble_core (load, step, 12-bit BCD out); FSM, alternation and pending logic stay in the top.

Verification
REQ-030 Reset then data_valid with humidity=57, temperature=23 -> done exactly 10 cycles later, tens=5, ones=7, src=0.
REQ-031 ALT_PERIOD=16, after REQ-030 -> at counter wrap conversion of 23: tens=2, ones=3, src=1; next wrap back to 5,7, src=0.
REQ-032 humidity=150: with DHT_BCD_SATURATE_EN -> 9,9; without -> 5,0; humidity=0 -> 0,0; humidity=99 -> 9,9 both builds.
REQ-033 data_valid with humidity=40 issued at CONV cycle 3 of prior conversion -> prior done unchanged, second done 11 cycles after first DONE edge ends, tens=4, ones=0.
REQ-034 rst_n low at CONV cycle 5 -> outputs 0 immediately, no done pulse for 20 cycles after release absent requests.
REQ-035 data_valid coincident with alternation wrap -> exactly one done pulse, src toggled, digits from new data.
